// File: rtl/spi_mosi_rx_buffer_pkg.sv
// Shared definitions for the MOSI receive buffer: state encoding, default sizes
// and the word-count helper.
package spi_mosi_rx_buffer_pkg;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_N            = 8;
  localparam int DEF_IDLE_TIMEOUT = 16;
  localparam int CNT_W            = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RX   = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } rx_state_t;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] i_cnt);
    return i_cnt + 5'd1;
  endfunction

endpackage

// File: rtl/spi_rx_shifter.sv
// MSB-first deserialiser: WIDTH-bit shift register with bit counter, a word_done
// strobe on the last bit of a word, and a partial flag used when CS aborts a word.
module spi_rx_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_shift,
  input  logic             i_abort,
  input  logic             i_mosi,
  output logic             o_word_done,
  output logic [WIDTH-1:0] o_word,
  output logic             o_partial
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic [WIDTH-2:0] r_shift;
  logic [BW-1:0]    r_bits;

  // The completed word includes the bit being sampled on this very edge.
  assign o_word      = {r_shift, i_mosi};
  assign o_word_done = i_shift && (r_bits == BIT_LAST);
  assign o_partial   = (r_bits != {BW{1'b0}});

  // Shift register and bit counter; abort drops any partially received word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shift <= {(WIDTH-1){1'b0}};
      r_bits  <= {BW{1'b0}};
    end else if (i_abort) begin
      r_bits  <= {BW{1'b0}};
    end else if (i_shift) begin
      r_shift <= o_word[WIDTH-2:0];
      r_bits  <= o_word_done ? {BW{1'b0}} : r_bits + {{(BW-1){1'b0}}, 1'b1};
    end else begin
      r_bits  <= r_bits;
    end
  end

endmodule

// File: rtl/spi_mosi_rx_buffer.sv
// Receive end of the MOSI SPI link: packs deserialised words and their DC flags
// into a frame buffer and reports completion by word count or CS idle timeout.
module spi_mosi_rx_buffer
  import spi_mosi_rx_buffer_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int N            = DEF_N,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic               i_SCK,
  input  logic               i_RST,
  input  logic               i_MOSI,
  input  logic               i_CS,
  input  logic               i_DC,
  input  logic [CNT_W-1:0]   i_N_EXPECT,
  output logic [WIDTH-1:0]   o_BYTE,
  output logic               o_BYTE_VALID,
  output logic               o_BYTE_DC,
  output logic [WIDTH*N-1:0] o_DATA,
  output logic [N-1:0]       o_DC,
  output logic [CNT_W-1:0]   o_N_RECEIVED,
  output logic               o_DONE,
  output logic               o_FRAME_ERR
);

  localparam int IW = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [IW-1:0]    IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] N_MAX     = CNT_W'(N);

  rx_state_t          r_state;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_n_exp;
  logic               r_err;
  logic [IW-1:0]      r_idle;
  logic [WIDTH*N-1:0] r_buf;
  logic [N-1:0]       r_dcb;

  logic               w_shift_en;
  logic               w_abort;
  logic               w_word_done;
  logic [WIDTH-1:0]   w_word;
  logic               w_partial;
  logic               w_store;
  logic               w_ovf;
  logic               w_hit;
  logic [CNT_W-1:0]   w_count_inc;
  logic [WIDTH*N-1:0] w_buf_nxt;
  logic [N-1:0]       w_dcb_nxt;

  // Bits are accepted in every state except the one-cycle DONE turnaround.
  assign w_shift_en  = (r_state != ST_DONE) && !i_CS;
  assign w_abort     = (r_state == ST_RX) && i_CS;
  assign w_count_inc = cnt_inc(r_count);
  assign w_store     = w_word_done && (r_count < N_MAX);
  assign w_ovf       = w_word_done && !w_store;
  assign w_hit       = w_store && (r_n_exp != 5'd0) && (w_count_inc == r_n_exp);

  spi_rx_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .i_clk       (i_SCK),
    .i_rst_n     (i_RST),
    .i_shift     (w_shift_en),
    .i_abort     (w_abort),
    .i_mosi      (i_MOSI),
    .o_word_done (w_word_done),
    .o_word      (w_word),
    .o_partial   (w_partial)
  );

  // Frame buffer view with the word completing this edge already in its slot.
  always_comb begin
    w_buf_nxt = r_buf;
    w_dcb_nxt = r_dcb;
    for (int k = 0; k < N; k++) begin
      if (w_store && (r_count == CNT_W'(k))) begin
        w_buf_nxt[WIDTH*k +: WIDTH] = w_word;
        w_dcb_nxt[k]                = i_DC;
      end else begin
        w_buf_nxt[WIDTH*k +: WIDTH] = r_buf[WIDTH*k +: WIDTH];
        w_dcb_nxt[k]                = r_dcb[k];
      end
    end
  end

  // Frame FSM, idle counter, buffer and all registered outputs.
  always_ff @(posedge i_SCK) begin
    if (!i_RST) begin
      r_state      <= ST_IDLE;
      r_count      <= 5'd0;
      r_n_exp      <= 5'd0;
      r_err        <= 1'b0;
      r_idle       <= {IW{1'b0}};
      r_buf        <= {(WIDTH*N){1'b0}};
      r_dcb        <= {N{1'b0}};
      o_BYTE       <= {WIDTH{1'b0}};
      o_BYTE_VALID <= 1'b0;
      o_BYTE_DC    <= 1'b0;
      o_DATA       <= {(WIDTH*N){1'b0}};
      o_DC         <= {N{1'b0}};
      o_N_RECEIVED <= 5'd0;
      o_DONE       <= 1'b0;
      o_FRAME_ERR  <= 1'b0;
    end else begin
      o_BYTE_VALID <= 1'b0;
      o_DONE       <= 1'b0;
      if (w_word_done) begin
        o_BYTE       <= w_word;
        o_BYTE_DC    <= i_DC;
        o_BYTE_VALID <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (!i_CS) begin
            r_state <= ST_RX;
            r_n_exp <= i_N_EXPECT;
            r_count <= 5'd0;
            r_err   <= 1'b0;
            r_idle  <= {IW{1'b0}};
            r_buf   <= {(WIDTH*N){1'b0}};
            r_dcb   <= {N{1'b0}};
          end
        end
        ST_RX: begin
          if (i_CS) begin
            r_state <= ST_GAP;
            r_idle  <= {IW{1'b0}};
            if (w_partial) begin
              r_err <= 1'b1;
            end
          end else begin
            r_buf <= w_buf_nxt;
            r_dcb <= w_dcb_nxt;
            if (w_store) begin
              r_count <= w_count_inc;
            end
            if (w_ovf) begin
              r_err <= 1'b1;
            end
            // Count-terminated frame: o_DONE coincides with the last o_BYTE_VALID.
            if (w_hit) begin
              r_state      <= ST_DONE;
              o_DONE       <= 1'b1;
              o_DATA       <= w_buf_nxt;
              o_DC         <= w_dcb_nxt;
              o_N_RECEIVED <= w_count_inc;
              o_FRAME_ERR  <= r_err;
            end
          end
        end
        ST_GAP: begin
          if (!i_CS) begin
            r_state <= ST_RX;
            r_idle  <= {IW{1'b0}};
          end else if (r_idle == IDLE_LAST) begin
            if (r_count != 5'd0) begin
              r_state      <= ST_DONE;
              o_DONE       <= 1'b1;
              o_DATA       <= r_buf;
              o_DC         <= r_dcb;
              o_N_RECEIVED <= r_count;
              o_FRAME_ERR  <= r_err;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_idle <= r_idle + {{(IW-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mosi_rx_buffer.sv
// Directed and randomized frames against a word-list model of the receive buffer.
module tb_spi_mosi_rx_buffer;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic        mosi;
  logic        dc;
  logic [4:0]  nexp;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        o_byte_dc;
  logic [63:0] o_data;
  logic [7:0]  o_dc;
  logic [4:0]  o_n_rec;
  logic        o_done;
  logic        o_ferr;

  int n_cmp = 0;
  int n_bad = 0;
  int ndone = 0;
  int done_cyc = 0;
  int cyc = 0;
  int rise_cyc = 0;

  logic [63:0] cap_data;
  logic [7:0]  cap_dc;
  logic [4:0]  cap_n;
  logic        cap_err;
  logic [8:0]  bq[$];
  logic [7:0]  tw[0:15];
  logic        tdc[0:15];
  logic [63:0] e_data;
  logic [7:0]  e_dc;
  int          e_n;
  logic        e_err;

  spi_mosi_rx_buffer #(.WIDTH(8), .N(8), .IDLE_TIMEOUT(T)) dut (
    .i_SCK        (clk),
    .i_RST        (rst_n),
    .i_MOSI       (mosi),
    .i_CS         (cs),
    .i_DC         (dc),
    .i_N_EXPECT   (nexp),
    .o_BYTE       (o_byte),
    .o_BYTE_VALID (o_byte_valid),
    .o_BYTE_DC    (o_byte_dc),
    .o_DATA       (o_data),
    .o_DC         (o_dc),
    .o_N_RECEIVED (o_n_rec),
    .o_DONE       (o_done),
    .o_FRAME_ERR  (o_ferr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_byte_valid) bq.push_back({o_byte_dc, o_byte});
    if (o_done) begin
      ndone    <= ndone + 1;
      done_cyc <= cyc;
      cap_data <= o_data;
      cap_dc   <= o_dc;
      cap_n    <= o_n_rec;
      cap_err  <= o_ferr;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] w, input logic d, input int nb);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      cs   = 1'b0;
      mosi = w[7-i];
      dc   = d;
    end
  endtask

  task automatic cs_high(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) rise_cyc = cyc;
      cs = 1'b1;
    end
  endtask

  // Frame expected from the list of complete words sent and the frame rules.
  task automatic model(input int nw, input int nx, input bit part);
    int n;
    n = (nx != 0 && nw >= nx) ? nx : ((nw > 8) ? 8 : nw);
    e_n    = n;
    e_err  = part || (nw > n);
    e_data = 64'd0;
    e_dc   = 8'd0;
    for (int k = 0; k < n; k++) begin
      e_data = e_data | (64'(tw[k]) << (8 * k));
      e_dc   = e_dc | (8'(tdc[k]) << k);
    end
  endtask

  task automatic check_frame(input string tag, input int d0, input int nw);
    chk({tag, "/ndone"}, 64'(ndone - d0), 64'd1);
    chk({tag, "/data"}, cap_data, e_data);
    chk({tag, "/dc"}, 64'(cap_dc), 64'(e_dc));
    chk({tag, "/nrec"}, 64'(cap_n), 64'(e_n));
    chk({tag, "/err"}, 64'(cap_err), 64'(e_err));
    if (nw <= 8) begin
      chk({tag, "/nbytes"}, 64'(bq.size()), 64'(nw));
      for (int k = 0; k < nw && k < bq.size(); k++)
        chk({tag, "/byte"}, 64'(bq[k]), 64'({tdc[k], tw[k]}));
    end
  endtask

  task automatic run_frame(input string tag, input int nw, input int nx,
                           input int pbits, input int gap, input bit chg);
    int d0;
    d0 = ndone;
    bq.delete();
    nexp = 5'(nx);
    for (int k = 0; k < nw; k++) begin
      send_bits(tw[k], tdc[k], 8);
      if (chg && k == 0) nexp = 5'($urandom_range(1, 31));
    end
    if (pbits > 0) send_bits(tw[nw], tdc[nw], pbits);
    cs_high(gap);
    model(nw, nx, pbits > 0);
    check_frame(tag, d0, nw);
  endtask

  task automatic rand_words(input int nw);
    for (int k = 0; k < nw; k++) begin
      tw[k]  = 8'($urandom_range(0, 255));
      tdc[k] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    int nw;
    logic [7:0] pat;
    rst_n = 1'b0; cs = 1'b1; mosi = 1'b0; dc = 1'b0; nexp = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst/data", o_data, 64'd0);
    chk("rst/dc", 64'(o_dc), 64'd0);
    chk("rst/nrec", 64'(o_n_rec), 64'd0);
    chk("rst/flags", 64'({o_done, o_ferr, o_byte_valid, o_byte_dc}), 64'd0);
    chk("rst/byte", 64'(o_byte), 64'd0);
    rst_n = 1'b1;
    cs_high(3);

    // Loopback frame: walking zero, DC pattern AA, count-terminated.
    pat = 8'hAA;
    for (int k = 0; k < 8; k++) begin
      tw[k]  = ~(8'd1 << k);
      tdc[k] = pat[k];
    end
    run_frame("loop8", 8, 8, 0, 2, 1'b0);
    chk("loop8/lit", cap_data, 64'h7FBFDFEFF7FBFDFE);

    // Back-to-back four-word frame with DC pattern 0C.
    pat = 8'h0C;
    tw[0] = 8'h03; tw[1] = 8'h0C; tw[2] = 8'h30; tw[3] = 8'hC0;
    for (int k = 0; k < 4; k++) tdc[k] = pat[k];
    run_frame("b2b4", 4, 4, 0, 2, 1'b0);
    chk("b2b4/lit", cap_data, 64'h00000000C0300C03);

    // Timeout-closed frame and its latency from the first CS-high edge.
    tw[0] = 8'h03; tw[1] = 8'h0C; tdc[0] = 1'b1; tdc[1] = 1'b0;
    run_frame("tmo2", 2, 0, 0, T + 4, 1'b0);
    chk("tmo2/latency", 64'(done_cyc - rise_cyc - 1), 64'(T));

    // CS high shorter than the timeout continues the same frame.
    rand_words(3);
    d0 = ndone; bq.delete(); nexp = 5'd0;
    send_bits(tw[0], tdc[0], 8);
    send_bits(tw[1], tdc[1], 8);
    cs_high(5);
    send_bits(tw[2], tdc[2], 8);
    cs_high(T + 4);
    model(3, 0, 1'b0);
    check_frame("cont3", d0, 3);
    chk("cont3/latency", 64'(done_cyc - rise_cyc - 1), 64'(T));

    // Truncated second word.
    rand_words(2);
    run_frame("part", 1, 0, 5, T + 4, 1'b0);

    // Nine words into an eight-slot frame.
    rand_words(9);
    run_frame("ovf9", 9, 0, 0, T + 4, 1'b0);

    // Reset in the middle of the third word.
    rand_words(3);
    d0 = ndone; nexp = 5'd8;
    send_bits(tw[0], tdc[0], 8);
    send_bits(tw[1], tdc[1], 8);
    send_bits(tw[2], tdc[2], 4);
    @(negedge clk); rst_n = 1'b0; cs = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstmid/data", o_data, 64'd0);
    chk("rstmid/dc", 64'(o_dc), 64'd0);
    chk("rstmid/nrec", 64'(o_n_rec), 64'd0);
    chk("rstmid/byte", 64'(o_byte), 64'd0);
    chk("rstmid/flags", 64'({o_done, o_ferr, o_byte_valid, o_byte_dc}), 64'd0);
    rst_n = 1'b1;
    cs_high(T + 4);
    chk("rstmid/nodone", 64'(ndone - d0), 64'd0);
    rand_words(5);
    run_frame("after_rst", 5, 5, 0, 3, 1'b0);

    // Randomized frames, some with i_N_EXPECT changed after the first word.
    for (int f = 0; f < 8; f++) begin
      nw = $urandom_range(1, 8);
      rand_words(nw);
      run_frame("rnd", nw, ($urandom_range(0, 1) == 1) ? nw : 0, 0, T + 4,
                1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
